// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CHECK state exists in the enum in every build. It is only reachable when
// IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// 8-to-32 big-endian word assembler. It keeps the first three bytes of a word.
// When the fourth byte arrives, it presents the complete word combinationally,
// together with a one-cycle word_full pulse.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [23:0] partial;
    logic [1:0]  byte_cnt;

    // Shift accepted bytes in MSB first and count bytes within the current word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its inputs as they were before this clock edge.
        if (reset || clear) begin
            partial  <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            partial  <= {partial[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word      = {partial, byte_data};
    assign word_full = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer.
// It takes a framed byte stream: COUNT_HI, COUNT_LO, 4*N payload bytes, and an
// optional CHK byte. It writes big-endian words from BASE_ADDR upward and holds
// the CPU in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        load_done,
    output logic        cpu_hold,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LAST = CHECK;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t               state, next_state;
    logic                 accept;
    logic [7:0]           count_hi;
    logic [COUNT_W-1:0]   count, count_new, word_idx;
    logic [31:0]          asm_word;
    logic                 word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]           chk;
`endif

    // Ready depends only on state, and it is forced low while reset is asserted.
    assign byte_ready = !reset && (state inside {IDLE, CNT_LO, DATA, CHECK, ERR});
    assign accept     = byte_valid && byte_ready;
    assign count_new  = {count_hi, byte_data};

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == IDLE),
        .shift_en  (accept && (state == DATA)),
        .byte_data (byte_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default before the case statement, so no
        // path through this block can leave a signal unassigned and infer a latch.
        next_state = state;
        wr_en      = 1'b0;
        load_done  = 1'b0;
        cpu_hold   = 1'b1;
        error      = 1'b0;
        case (state)
            IDLE:   if (accept) next_state = CNT_LO;
            CNT_LO: if (accept) begin
                        if ({16'd0, count_new} > MAX_WORDS_U) next_state = ERR;
                        else if (count_new == '0)             next_state = AFTER_LAST;
                        else                                  next_state = DATA;
                    end
            DATA:   if (word_full) next_state = WRITE;
            WRITE:  begin
                        wr_en      = 1'b1;
                        next_state = (word_idx + 16'd1 == count) ? AFTER_LAST : DATA;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:  if (accept) next_state = (byte_data == chk) ? DONE : ERR;
`endif
            DONE:   begin
                        load_done = 1'b1;
                        cpu_hold  = 1'b0;
                    end
            ERR:    error = 1'b1;
            default: next_state = IDLE;
        endcase
        // The CPU goes back into reset on the same cycle that reset is raised.
        if (reset) cpu_hold = 1'b1;
    end

    // Datapath: count capture, word index, and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi <= '0;
            count    <= '0;
            word_idx <= '0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= '0;
        end else begin
            if (state == IDLE && accept) count_hi <= byte_data;
            if (state == CNT_LO && accept) begin
                count    <= count_new;
                word_idx <= '0;
            end
            // Load the write port on the 4th byte, so it is valid for the whole WRITE cycle.
            if (word_full) begin
                wr_addr <= BASE_ADDR + 32'(word_idx) * 32'(BYTES_PER_WORD);
                wr_data <= asm_word;
            end
            if (state == WRITE) word_idx <= word_idx + 16'd1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over the count bytes and all payload bytes; COUNT_HI restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk <= '0;
        end else if (accept) begin
            if (state == IDLE)                         chk <= byte_data;
            else if (state == CNT_LO || state == DATA) chk <= chk ^ byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. It runs two instances on the same byte
// stream: one with the default base address and one at 0x0040_0000. Expected
// writes and final status come from a frame-level reference model.
// This bench follows IMEM_LOADER_CHECKSUM_EN in the same way the design does.
module tb_imem_loader;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0040_0000;
    localparam int          MAX   = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        ready [2];
    logic        wr_en [2];
    logic [31:0] wr_addr [2];
    logic [31:0] wr_data [2];
    logic        load_done [2];
    logic        cpu_hold [2];
    logic        error [2];

    int tests = 0;
    int failed = 0;
    int hold_err = 0;
    int ready_err = 0;
    logic [64:0] wq[$];              // {dut, addr, data} for every observed write
    logic [31:0] last_addr [2];
    logic [31:0] last_data [2];

    imem_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAX)) dut0 (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .load_done(load_done[0]), .cpu_hold(cpu_hold[0]), .error(error[0])
    );

    imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX)) dut1 (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .load_done(load_done[1]), .cpu_hold(cpu_hold[1]), .error(error[1])
    );

    always #5 clk = ~clk;

    // Write monitor: logs writes, checks ready is low during a write, and checks the port holds otherwise.
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                last_addr[d] = (d == 1) ? BASE1 : BASE0;
                last_data[d] = 32'h0;
            end else if (wr_en[d]) begin
                wq.push_back({1'(d), wr_addr[d], wr_data[d]});
                last_addr[d] = wr_addr[d];
                last_data[d] = wr_data[d];
                if (ready[d]) ready_err++;
            end else if (wr_addr[d] !== last_addr[d] || wr_data[d] !== last_data[d]) begin
                hold_err++;
            end
        end
        if (ready[0] !== ready[1]) ready_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference frame builder: count, payload words MSB first, then the optional XOR checksum.
    task automatic build_frame(input int n, input logic [31:0] w[$], input bit corrupt,
                               output logic [7:0] q[$]);
        logic [7:0]  x;
        logic [31:0] nn;
        logic [31:0] wd;
        nn = 32'(n);
        q  = {};
        q.push_back(nn[15:8]);
        q.push_back(nn[7:0]);
        x = nn[15:8] ^ nn[7:0];
        if (n > MAX) begin
            for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < n; i++) begin
                wd = w[i];
                for (int b = 3; b >= 0; b--) begin
                    q.push_back(wd[8*b +: 8]);
                    x = x ^ wd[8*b +: 8];
                end
            end
            if (CHK_ON) q.push_back(corrupt ? (x ^ 8'h5A) : x);
        end
    endtask

    // Mode 0 holds byte_valid high, mode 1 toggles it 1-0-1, and mode 2 randomises it.
    task automatic drive_bytes(input logic [7:0] q[$], input int mode);
        int idx = 0;
        int cyc = 0;
        while (idx < q.size() && cyc < 20 * q.size() + 50) begin
            @(negedge clk);
            byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            byte_data  = q[idx];
            if (byte_valid && ready[0]) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check("bytes_consumed", idx, q.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("hold_in_reset_cycle", cpu_hold[d], 1'b1);
            check("ready_in_reset", ready[d], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_wr_en", wr_en[d], 1'b0);
            check("rst_wr_addr", wr_addr[d], (d == 1) ? BASE1 : BASE0);
            check("rst_wr_data", wr_data[d], 32'h0);
            check("rst_load_done", load_done[d], 1'b0);
            check("rst_cpu_hold", cpu_hold[d], 1'b1);
            check("rst_error", error[d], 1'b0);
            check("rst_ready", ready[d], 1'b1);
        end
        wq.delete();
        hold_err  = 0;
        ready_err = 0;
    endtask

    task automatic check_writes(input int n_exp, input logic [31:0] w[$]);
        int k [2] = '{0, 0};
        int d;
        logic [31:0] base;
        foreach (wq[i]) begin
            d    = int'(wq[i][64]);
            base = (d == 1) ? BASE1 : BASE0;
            if (k[d] < n_exp) begin
                check($sformatf("wr_addr%0d[%0d]", d, k[d]), wq[i][63:32], base + 32'(k[d]) * 4);
                check($sformatf("wr_data%0d[%0d]", d, k[d]), wq[i][31:0], w[k[d]]);
            end
            k[d]++;
        end
        check("write_count0", k[0], n_exp);
        check("write_count1", k[1], n_exp);
        wq.delete();
    endtask

    task automatic run_frame(input int n, input logic [31:0] w[$], input bit corrupt, input int mode);
        logic [7:0] q[$];
        bit exp_err;
        build_frame(n, w, corrupt, q);
        drive_bytes(q, mode);
        repeat (4) @(negedge clk);
        exp_err = (n > MAX) || (CHK_ON && corrupt);
        check_writes((n > MAX) ? 0 : n, w);
        for (int d = 0; d < 2; d++) begin
            check("load_done", load_done[d], !exp_err);
            check("error", error[d], exp_err);
            check("cpu_hold", cpu_hold[d], exp_err);
        end
        check("port_hold_violations", hold_err, 0);
        check("ready_in_write_violations", ready_err, 0);
    endtask

    task automatic rand_words(input int n, output logic [31:0] w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [7:0]  part[$];
        int n;

        repeat (2) @(negedge clk);
        do_reset();

        // Directed two-word image with byte_valid held high, then toggled.
        w = '{32'h2008_0005, 32'h8C09_0004};
        run_frame(2, w, 1'b0, 0);
        do_reset();
        run_frame(2, w, 1'b0, 1);
        do_reset();

        // Count bounds: MAX+1 is rejected and MAX is accepted.
        w = {};
        run_frame(MAX + 1, w, 1'b0, 0);
        do_reset();
        rand_words(MAX, w);
        run_frame(MAX, w, 1'b0, 0);
        do_reset();

        // An empty image, then a single word followed by a corrupted checksum byte.
        w = {};
        run_frame(0, w, 1'b0, 0);
        do_reset();
        w = '{32'h1234_5678};
        run_frame(1, w, 1'b1, 0);
        do_reset();

        // Reset mid-frame after two payload bytes, then a clean one-word frame.
        part = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        drive_bytes(part, 0);
        repeat (2) @(negedge clk);
        check("partial_no_write", wq.size(), 0);
        do_reset();
        w = '{32'h0000_000C};
        run_frame(1, w, 1'b0, 0);
        do_reset();

        // Three-word image, giving the 0x400000/4/8 address sequence on the offset instance.
        rand_words(3, w);
        run_frame(3, w, 1'b0, 0);
        do_reset();

        // Random frames with random flow control and occasional bad checksums.
        repeat (6) begin
            n = $urandom_range(0, 5);
            rand_words(n, w);
            run_frame(n, w, ($urandom_range(0, 3) == 0), 2);
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
